// File: rtl/l2_cache_control.sv
// ---------------------------------------------------------------------------
// l2_cache_control
//   Control FSM for the unified N-way L2 cache datapath sitting below the
//   I/D arbiter. It takes one read/write request at a time and resolves
//   hit/miss. On a miss it writes back a dirty victim and allocates the line
//   from physical memory. It drives every datapath load/select strobe and
//   keeps saturating hit and miss counters.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   mem_read, mem_write        arbiter request (held until mem_resp)
//   mem_resp                   request complete, 1-cycle pulse
//   hit, hit_way               datapath tag match and matching way
//   lru_way                    current LRU way from the datapath
//   victim_dirty               valid&dirty of the way selected by way_sel
//   way_sel                    way addressed by load strobes / victim mux
//   load_data/tag/valid/dirty  datapath array write strobes
//   dirty_in                   value written on load_dirty
//   load_lru                   mark way_sel most-recently-used
//   data_in_sel                0 = merged upstream wdata, 1 = pmem_rdata
//   pmem_addr_sel              0 = request address, 1 = {victim tag, index}
//   pmem_read, pmem_write      physical memory request (held until pmem_resp)
//   pmem_resp                  physical memory done, 1-cycle pulse
//   hit_count, miss_count      saturating event counters
// ---------------------------------------------------------------------------
module l2_cache_control #(
  parameter int WAYS  = 2,
  parameter int CNT_W = 16,
  localparam int WW   = (WAYS > 2) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic [WW-1:0]    hit_way,
  input  logic [WW-1:0]    lru_way,
  input  logic             victim_dirty,
  output logic [WW-1:0]    way_sel,
  output logic             load_data,
  output logic             load_tag,
  output logic             load_valid,
  output logic             load_dirty,
  output logic             dirty_in,
  output logic             load_lru,
  output logic             data_in_sel,
  output logic             pmem_addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CHECK     = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] ALLOCATE  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [WW-1:0]    victim_reg;
  // Set when CHECK is entered straight from a line fill, so the re-check is
  // counted neither as a hit nor as a second miss.
  logic             refill_reg;
  logic [CNT_W-1:0] hit_count_reg, miss_count_reg;

  logic req;
  logic check_hit, check_miss;

  assign req        = mem_read | mem_write;
  assign check_hit  = (state_reg == CHECK) && req && hit;
  assign check_miss = (state_reg == CHECK) && req && !hit;

  always_comb begin
    state_next    = state_reg;
    mem_resp      = 1'b0;
    way_sel       = victim_reg;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    data_in_sel   = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Outputs stay zero here, so the block is quiet out of reset.
        if (req) state_next = CHECK;
      end
      CHECK: begin
        if (!req) begin
          // Request withdrawn while a miss was being serviced.
          state_next = IDLE;
        end else if (hit) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          load_lru = 1'b1;
          // A simultaneous read+write is handled as a write.
          if (mem_write) begin
            load_data  = 1'b1;
            load_dirty = 1'b1;
            dirty_in   = 1'b1;
          end
          state_next = IDLE;
        end else begin
          // victim_dirty reflects way_sel, so point it at the LRU way now.
          way_sel    = lru_way;
          state_next = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_in_sel = 1'b1;
          load_data   = 1'b1;
          load_tag    = 1'b1;
          load_valid  = 1'b1;
          load_dirty  = 1'b1;
          state_next  = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      victim_reg     <= '0;
      refill_reg     <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Latch the victim once so LRU traffic during the miss cannot move it.
      if (check_miss) victim_reg <= lru_way;
      if (state_reg == ALLOCATE && pmem_resp)
        refill_reg <= 1'b1;
      else if (state_reg == CHECK)
        refill_reg <= 1'b0;
      if (check_hit && !refill_reg && hit_count_reg != {CNT_W{1'b1}})
        hit_count_reg <= hit_count_reg + 1'b1;
      if (check_miss && !refill_reg && miss_count_reg != {CNT_W{1'b1}})
        miss_count_reg <= miss_count_reg + 1'b1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_l2_cache_control.sv
module tb_l2_cache_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_read, mem_write, hit, victim_dirty, pmem_resp;
  logic [0:0]  hit_way, lru_way;
  logic        mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in;
  logic        load_lru, data_in_sel, pmem_addr_sel, pmem_read, pmem_write;
  logic [0:0]  way_sel;
  logic [15:0] hit_count, miss_count;

  // Second instance with narrow counters for the saturation check.
  logic        mem_resp_4, load_data_4, load_tag_4, load_valid_4, load_dirty_4;
  logic        dirty_in_4, load_lru_4, data_in_sel_4, pmem_addr_sel_4;
  logic        pmem_read_4, pmem_write_4;
  logic [0:0]  way_sel_4;
  logic [3:0]  hit_count_4, miss_count_4;

  int compared = 0;
  int mismatched = 0;

  l2_cache_control #(.WAYS(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit(hit), .hit_way(hit_way), .lru_way(lru_way),
    .victim_dirty(victim_dirty), .way_sel(way_sel), .load_data(load_data),
    .load_tag(load_tag), .load_valid(load_valid), .load_dirty(load_dirty),
    .dirty_in(dirty_in), .load_lru(load_lru), .data_in_sel(data_in_sel),
    .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
  );

  l2_cache_control #(.WAYS(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp_4), .hit(hit), .hit_way(hit_way), .lru_way(lru_way),
    .victim_dirty(victim_dirty), .way_sel(way_sel_4), .load_data(load_data_4),
    .load_tag(load_tag_4), .load_valid(load_valid_4), .load_dirty(load_dirty_4),
    .dirty_in(dirty_in_4), .load_lru(load_lru_4), .data_in_sel(data_in_sel_4),
    .pmem_addr_sel(pmem_addr_sel_4), .pmem_read(pmem_read_4), .pmem_write(pmem_write_4),
    .pmem_resp(pmem_resp), .hit_count(hit_count_4), .miss_count(miss_count_4)
  );

  // All single-bit outputs packed together for "everything idle" checks.
  logic [10:0] strobes;
  assign strobes = {mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
                    load_lru, data_in_sel, pmem_addr_sel, pmem_read, pmem_write};

  // Inputs change 1 time unit after the rising edge; outputs are sampled a
  // further time unit later, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    mem_read = 0; mem_write = 0; hit = 0; hit_way = 0; lru_way = 0;
    victim_dirty = 0; pmem_resp = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    settle();
    compared++; if (strobes !== 11'd0) begin mismatched++; $display("FAIL reset_strobes: got %b expected %b", strobes, 11'd0); end
    compared++; if (way_sel !== 1'b0) begin mismatched++; $display("FAIL reset_way_sel: got %0d expected 0", way_sel); end
    compared++; if (hit_count !== 16'd0) begin mismatched++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
    compared++; if (miss_count !== 16'd0) begin mismatched++; $display("FAIL reset_miss_count: got %0d expected 0", miss_count); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_read_hit();
    apply_reset();
    // cycle 0: IDLE sees the request
    mem_read = 1; hit = 1; hit_way = 1;
    settle();
    compared++; if (mem_resp !== 1'b0) begin mismatched++; $display("FAIL rd_hit_c0_resp: got %b expected 0", mem_resp); end
    tick(); // cycle 1: CHECK
    compared++; if (mem_resp !== 1'b1) begin mismatched++; $display("FAIL rd_hit_resp: got %b expected 1", mem_resp); end
    compared++; if (way_sel !== 1'b1) begin mismatched++; $display("FAIL rd_hit_way_sel: got %0d expected 1", way_sel); end
    compared++; if (load_lru !== 1'b1) begin mismatched++; $display("FAIL rd_hit_load_lru: got %b expected 1", load_lru); end
    compared++; if (load_data !== 1'b0) begin mismatched++; $display("FAIL rd_hit_load_data: got %b expected 0", load_data); end
    tick();
    mem_read = 0; hit = 0;
    settle();
    compared++; if (hit_count !== 16'd1) begin mismatched++; $display("FAIL rd_hit_count: got %0d expected 1", hit_count); end
    compared++; if (mem_resp !== 1'b0) begin mismatched++; $display("FAIL rd_hit_resp_pulse: got %b expected 0", mem_resp); end
    $display("test_read_hit: read hit on way 1");
  endtask

  task automatic test_write_hit();
    apply_reset();
    mem_write = 1; hit = 1; hit_way = 0; lru_way = 1;
    tick(); // CHECK
    compared++; if (mem_resp !== 1'b1) begin mismatched++; $display("FAIL wr_hit_resp: got %b expected 1", mem_resp); end
    compared++; if ({load_data, load_dirty, dirty_in, data_in_sel, load_lru} !== 5'b11101) begin
      mismatched++; $display("FAIL wr_hit_strobes: got %b expected %b", {load_data, load_dirty, dirty_in, data_in_sel, load_lru}, 5'b11101); end
    compared++; if (way_sel !== 1'b0) begin mismatched++; $display("FAIL wr_hit_way_sel: got %0d expected 0", way_sel); end
    tick();
    mem_write = 0; hit = 0;
    // read and write together behave as a write
    tick();
    mem_read = 1; mem_write = 1; hit = 1; hit_way = 1;
    tick();
    compared++; if ({load_data, load_dirty, dirty_in} !== 3'b111) begin
      mismatched++; $display("FAIL rw_hit_strobes: got %b expected 111", {load_data, load_dirty, dirty_in}); end
    tick();
    mem_read = 0; mem_write = 0; hit = 0;
    settle();
    compared++; if (hit_count !== 16'd2) begin mismatched++; $display("FAIL wr_hit_count: got %0d expected 2", hit_count); end
    $display("test_write_hit: write hit and read+write hit");
  endtask

  task automatic test_clean_miss();
    apply_reset();
    mem_read = 1; hit = 0; lru_way = 1; victim_dirty = 0;
    tick(); // cycle 1 CHECK miss
    compared++; if (way_sel !== 1'b1) begin mismatched++; $display("FAIL cm_check_way_sel: got %0d expected 1", way_sel); end
    compared++; if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      mismatched++; $display("FAIL cm_check_strobes: got %b expected 000", {mem_resp, pmem_read, pmem_write}); end
    tick(); // cycle 2 ALLOCATE
    lru_way = 0;
    settle();
    compared++; if ({pmem_read, pmem_write, pmem_addr_sel, load_data} !== 4'b1000) begin
      mismatched++; $display("FAIL cm_alloc: got %b expected 1000", {pmem_read, pmem_write, pmem_addr_sel, load_data}); end
    tick(); tick(); // cycles 3,4 waiting
    compared++; if (pmem_read !== 1'b1) begin mismatched++; $display("FAIL cm_alloc_hold: got %b expected 1", pmem_read); end
    tick(); // cycle 5: pmem_resp
    pmem_resp = 1; hit = 1; hit_way = 1;
    settle();
    compared++; if ({data_in_sel, load_data, load_tag, load_valid, load_dirty, dirty_in} !== 6'b111110) begin
      mismatched++; $display("FAIL cm_fill: got %b expected 111110", {data_in_sel, load_data, load_tag, load_valid, load_dirty, dirty_in}); end
    compared++; if (way_sel !== 1'b1) begin mismatched++; $display("FAIL cm_fill_way_sel: got %0d expected 1", way_sel); end
    tick(); // cycle 6: re-check hits
    pmem_resp = 0;
    settle();
    compared++; if (mem_resp !== 1'b1) begin mismatched++; $display("FAIL cm_resp: got %b expected 1", mem_resp); end
    tick();
    mem_read = 0; hit = 0;
    settle();
    compared++; if (miss_count !== 16'd1) begin mismatched++; $display("FAIL cm_miss_count: got %0d expected 1", miss_count); end
    compared++; if (hit_count !== 16'd0) begin mismatched++; $display("FAIL cm_hit_count: got %0d expected 0", hit_count); end
    $display("test_clean_miss: allocate into way 1");
  endtask

  task automatic test_dirty_miss();
    apply_reset();
    mem_write = 1; hit = 0; lru_way = 0; victim_dirty = 1;
    tick(); // CHECK miss
    compared++; if (way_sel !== 1'b0) begin mismatched++; $display("FAIL dm_check_way_sel: got %0d expected 0", way_sel); end
    tick(); // WRITEBACK
    lru_way = 1; victim_dirty = 0;
    settle();
    compared++; if ({pmem_write, pmem_read, pmem_addr_sel} !== 3'b101) begin
      mismatched++; $display("FAIL dm_wb: got %b expected 101", {pmem_write, pmem_read, pmem_addr_sel}); end
    compared++; if (way_sel !== 1'b0) begin mismatched++; $display("FAIL dm_wb_way_sel: got %0d expected 0", way_sel); end
    tick();
    pmem_resp = 1;
    settle();
    compared++; if (load_data !== 1'b0) begin mismatched++; $display("FAIL dm_wb_resp_load: got %b expected 0", load_data); end
    tick(); // ALLOCATE
    pmem_resp = 0;
    settle();
    compared++; if ({pmem_write, pmem_read, pmem_addr_sel} !== 3'b010) begin
      mismatched++; $display("FAIL dm_alloc: got %b expected 010", {pmem_write, pmem_read, pmem_addr_sel}); end
    compared++; if (way_sel !== 1'b0) begin mismatched++; $display("FAIL dm_alloc_way_sel: got %0d expected 0", way_sel); end
    pmem_resp = 1; hit = 1; hit_way = 0;
    settle();
    compared++; if (load_tag !== 1'b1) begin mismatched++; $display("FAIL dm_fill_tag: got %b expected 1", load_tag); end
    tick(); // CHECK hit, write merges upstream data
    pmem_resp = 0;
    settle();
    compared++; if ({mem_resp, load_data, data_in_sel, dirty_in} !== 4'b1101) begin
      mismatched++; $display("FAIL dm_resp: got %b expected 1101", {mem_resp, load_data, data_in_sel, dirty_in}); end
    tick();
    mem_write = 0; hit = 0;
    settle();
    compared++; if ({miss_count, hit_count} !== {16'd1, 16'd0}) begin
      mismatched++; $display("FAIL dm_counts: got miss=%0d hit=%0d expected miss=1 hit=0", miss_count, hit_count); end
    $display("test_dirty_miss: writeback then allocate way 0");
  endtask

  task automatic test_drop_and_stray();
    apply_reset();
    // stray pmem_resp in IDLE is ignored
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    settle();
    compared++; if (strobes !== 11'd0) begin mismatched++; $display("FAIL stray_resp: got %b expected %b", strobes, 11'd0); end
    // request withdrawn during ALLOCATE
    mem_read = 1; hit = 0; lru_way = 1; victim_dirty = 0;
    tick(); tick(); // ALLOCATE
    mem_read = 0;
    tick();
    compared++; if (pmem_read !== 1'b1) begin mismatched++; $display("FAIL drop_pmem_held: got %b expected 1", pmem_read); end
    pmem_resp = 1; hit = 1; hit_way = 1;
    tick(); // CHECK with no request
    pmem_resp = 0;
    settle();
    compared++; if (mem_resp !== 1'b0) begin mismatched++; $display("FAIL drop_resp: got %b expected 0", mem_resp); end
    tick();
    compared++; if ({strobes, hit_count, miss_count} !== {11'd0, 16'd0, 16'd1}) begin
      mismatched++; $display("FAIL drop_idle: got %b hit=%0d miss=%0d expected idle hit=0 miss=1", strobes, hit_count, miss_count); end
    hit = 0;
    $display("test_drop_and_stray: stray pmem_resp and dropped request");
  endtask

  task automatic test_saturation();
    apply_reset();
    mem_read = 1; hit = 1; hit_way = 0;
    // back-to-back hits: IDLE and CHECK alternate while the request is held
    for (int i = 0; i < 34; i++) tick();
    mem_read = 0; hit = 0;
    tick();
    compared++; if (hit_count_4 !== 4'd15) begin mismatched++; $display("FAIL sat_hit_count_4: got %0d expected 15", hit_count_4); end
    compared++; if (hit_count !== 16'd17) begin mismatched++; $display("FAIL sat_hit_count_16: got %0d expected 17", hit_count); end
    $display("test_saturation: 17 back-to-back hits");
  endtask

  task automatic test_reset_mid_miss();
    apply_reset();
    mem_read = 1; hit = 0; lru_way = 0; victim_dirty = 0;
    tick(); tick(); // ALLOCATE
    compared++; if ({pmem_read, miss_count} !== {1'b1, 16'd1}) begin
      mismatched++; $display("FAIL rst_mid_pre: got pmem_read=%b miss=%0d expected 1/1", pmem_read, miss_count); end
    rst_n = 0;
    tick();
    compared++; if ({pmem_read, pmem_write} !== 2'b00) begin
      mismatched++; $display("FAIL rst_mid_pmem: got %b expected 00", {pmem_read, pmem_write}); end
    compared++; if ({hit_count, miss_count} !== 32'd0) begin
      mismatched++; $display("FAIL rst_mid_counts: got hit=%0d miss=%0d expected 0", hit_count, miss_count); end
    mem_read = 0;
    rst_n = 1;
    tick();
    compared++; if (strobes !== 11'd0) begin mismatched++; $display("FAIL rst_mid_idle: got %b expected %b", strobes, 11'd0); end
    $display("test_reset_mid_miss: reset during allocate");
  endtask

  initial begin
    rst_n = 0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_drop_and_stray();
    test_saturation();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
